spatz_vrf_rd_streamer: RTL and testbench

SPATZ_VRF_RD_STREAMER -- requirements
Module: spatz_vrf_rd_streamer

---
 rtl/spatz_vrf_rd_streamer.sv | 125 ++++++++++++
 tb/tb_spatz_vrf_rd_streamer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/spatz_vrf_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module  : spatz_vrf_rd_streamer
// Brief   : Streams a run of consecutive VRF words into a small response FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module spatz_vrf_rd_streamer #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned LenWidth  = 8,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic                 flush_i,
    output logic                 re_o,
    output logic [AddrWidth-1:0] raddr_o,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_last_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FULL_CNT = CntW'(FifoDepth);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  rem_q, rem_d;
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DataWidth-1:0] mem_data_q [FifoDepth];
    logic                 mem_last_q [FifoDepth];

    logic grant, accept, pop, is_last;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;

        req_ready_o  = (state_q == IDLE);
        re_o         = (state_q == READ) && (cnt_q < FULL_CNT);
        data_valid_o = (cnt_q != '0);
        busy_o       = (state_q == READ) || data_valid_o;
        raddr_o      = addr_q;

        // A grant or request coinciding with a flush is dropped outright.
        grant   = re_o && rvalid_i && !flush_i;
        accept  = req_valid_i && req_ready_o && !flush_i;
        pop     = data_valid_o && data_ready_i;
        is_last = (rem_q == LenWidth'(1));

        if (accept && (req_len_i != '0)) begin
            state_d = READ;
            addr_d  = req_addr_i;
            rem_d   = req_len_i;
        end
        if (grant) begin
            addr_d = addr_q + AddrWidth'(1);
            rem_d  = rem_q - LenWidth'(1);
            wptr_d = wptr_q + PtrW'(1);
            if (is_last) state_d = IDLE;
        end
        if (pop) rptr_d = rptr_q + PtrW'(1);
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the empty-FIFO output mux hides stale entries.
    always_ff @(posedge clk_i) begin
        if (grant && !rst_i) begin
            mem_data_q[wptr_q] <= rdata_i;
            mem_last_q[wptr_q] <= is_last;
        end
    end

    assign data_o      = data_valid_o ? mem_data_q[rptr_q] : '0;
    assign data_last_o = data_valid_o ? mem_last_q[rptr_q] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spatz_vrf_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_spatz_vrf_rd_streamer
// Brief   : Randomized bench with a queue-based transaction reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spatz_vrf_rd_streamer;

    localparam int AW   = 10;
    localparam int DW   = 64;
    localparam int LW   = 8;
    localparam int FD   = 4;
    localparam int NCYC = 6000;

    logic          clk = 1'b0;
    logic          rst_i, req_valid_i, req_ready_o, flush_i, re_o, rvalid_i;
    logic [AW-1:0] req_addr_i, raddr_o;
    logic [LW-1:0] req_len_i;
    logic [DW-1:0] rdata_i, data_o;
    logic          data_valid_o, data_ready_i, data_last_o, busy_o;

    spatz_vrf_rd_streamer #(
        .AddrWidth(AW), .DataWidth(DW), .LenWidth(LW), .FifoDepth(FD)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .flush_i(flush_i),
        .re_o(re_o), .raddr_o(raddr_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .data_o(data_o), .data_last_o(data_last_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a stream is "words still owed" starting at an address;
    // the response buffer is a plain queue of {last, data}.
    logic [DW:0]   m_q[$];
    logic          m_read;
    logic [AW-1:0] m_addr;
    int            m_rem;

    initial begin
        int p_rv, p_rdy;
        int sz;
        logic rd0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        flush_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; data_ready_i = 1'b0;
        m_read = 1'b0; m_addr = '0; m_rem = 0;
        p_rv = 70; p_rdy = 60;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc % 400 == 0) begin
                p_rv  = $urandom_range(20, 100);
                p_rdy = $urandom_range(0, 100);
            end
            rst_i        = (cyc < 3) || ($urandom_range(0, 299) == 0);
            flush_i      = ($urandom_range(0, 99) == 0);
            req_valid_i  = ($urandom_range(0, 1) == 1);
            req_len_i    = LW'($urandom_range(0, 9));
            req_addr_i   = ($urandom_range(0, 3) == 0) ? AW'((1 << AW) - $urandom_range(1, 3))
                                                       : AW'($urandom);
            rvalid_i     = ($urandom_range(0, 99) < p_rv);
            data_ready_i = ($urandom_range(0, 99) < p_rdy);
            rdata_i      = {$urandom, $urandom};
            #1;

            sz = m_q.size();
            check("req_ready", 128'(req_ready_o), 128'(!m_read));
            check("re", 128'(re_o), 128'(m_read && sz < FD));
            check("raddr", 128'(raddr_o), 128'(m_addr));
            check("data_valid", 128'(data_valid_o), 128'(sz != 0));
            check("busy", 128'(busy_o), 128'(m_read || sz != 0));
            if (sz != 0) begin
                check("data", 128'(data_o), 128'(m_q[0][DW-1:0]));
                check("last", 128'(data_last_o), 128'(m_q[0][DW]));
            end else begin
                check("data_idle", 128'(data_o), 128'(0));
                check("last_idle", 128'(data_last_o), 128'(0));
            end

            rd0 = m_read;
            if (rst_i) begin
                m_q.delete(); m_read = 1'b0; m_addr = '0; m_rem = 0;
            end else if (flush_i) begin
                m_q.delete(); m_read = 1'b0;
            end else begin
                if (sz != 0 && data_ready_i) void'(m_q.pop_front());
                if (rd0 && sz < FD && rvalid_i) begin
                    m_q.push_back({(m_rem == 1), rdata_i});
                    m_addr = m_addr + 1'b1;
                    m_rem--;
                    if (m_rem == 0) m_read = 1'b0;
                end
                if (!rd0 && req_valid_i && req_len_i != 0) begin
                    m_read = 1'b1;
                    m_addr = req_addr_i;
                    m_rem  = int'(req_len_i);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
